// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants and state type for the mux round-robin arbiter
package mux_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam logic [N_REQ-1:0] GNT_RST = '0;
    localparam logic [SEL_W-1:0] SEL_RST = '0;

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational rotate-and-find-first picker over eight requests
import mux_arb_pkg::*;

module rr_pick8 (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   off;

    always_comb begin
        // Rotating right by ptr puts the search start at bit 0.
        dbl   = {req, req} >> ptr;
        rot   = dbl[N_REQ-1:0];
        found = 1'b0;
        off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = i[SEL_W-1:0];
            end
        end
        idx    = ptr + off;
        onehot = N_REQ'(1) << idx;
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin owner arbiter driving the 8-to-1 mux select
// Optional hold-time preemption is built when MUX_ARB_TIMEOUT_EN is defined.
import mux_arb_pkg::*;

module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] sel,
    output logic             preempt
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             pre_q, pre_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             timeout;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;

    rr_pick8 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

`ifdef MUX_ARB_TIMEOUT_EN
    assign timeout = (cnt_q == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end
`else
    // No counter: grants are held for as long as the owner requests.
    assign timeout = 1'b0 & (HOLD_LAST != 8'd0);
    assign cnt_q   = 8'd0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        pre_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_onehot;
                    sel_d   = pick_idx;
                    valid_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // sel_q is the owner index for the whole BUSY period.
                if (!req[sel_q] || timeout) begin
                    gnt_d   = GNT_RST;
                    valid_d = 1'b0;
                    ptr_d   = sel_q + SEL_W'(1);
                    pre_d   = req[sel_q] & timeout;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= GNT_RST;
            sel_q   <= SEL_RST;
            valid_q <= 1'b0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            pre_q   <= pre_d;
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    assign preempt = pre_q;
`else
    assign preempt = 1'b0 & pre_q;
`endif

    assign gnt       = gnt_q;
    assign gnt_valid = valid_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed and randomized checks of mux_rr_arbiter against a reference model
module tb_mux_rr_arbiter;

    localparam int TB_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] sel;
    logic       preempt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: owner index (-1 = none), search start, dead-cycle flag.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_cnt   = 0;
    bit m_gap   = 1'b0;
    bit m_pre   = 1'b0;

    mux_rr_arbiter #(.MAX_HOLD(TB_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .sel       (sel),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_sel = 0; m_cnt = 0; m_gap = 1'b0; m_pre = 1'b0;
    endtask

    task automatic model_update(input logic [7:0] r);
        bit tmo;
        m_pre = 1'b0;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_ptr + k) % 8;
                if (r[c]) begin
                    m_owner = c; m_sel = c; m_cnt = 0;
                    break;
                end
            end
        end else begin
`ifdef MUX_ARB_TIMEOUT_EN
            tmo = (m_cnt == TB_HOLD - 1);
`else
            tmo = 1'b0;
`endif
            if (!r[m_owner] || tmo) begin
                m_pre   = r[m_owner] && tmo;
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] eg;
        eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        check_val({tag, ".gnt"}, gnt, eg);
        check_val({tag, ".valid"}, {7'd0, gnt_valid}, {7'd0, m_owner >= 0});
        check_val({tag, ".sel"}, {5'd0, sel}, 8'(m_sel));
        check_val({tag, ".preempt"}, {7'd0, preempt}, {7'd0, m_pre});
    endtask

    task automatic step(input logic [7:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_update(r);
        #1;
        check_model(tag);
    endtask

    int         order[$];
    logic [7:0] r;
    int         hold;

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset.gnt", gnt, 8'h00);
        check_val("reset.sel", {5'd0, sel}, 8'd0);
        check_val("reset.valid", {7'd0, gnt_valid}, 8'd0);
        check_val("reset.preempt", {7'd0, preempt}, 8'd0);
        rst_n = 1'b1;

        // Single requester held five cycles then dropped
        hold = 0;
        for (int i = 0; i < 5; i++) begin
            step(8'h04, "single");
            if (gnt === 8'h04 && sel === 3'd2) hold++;
        end
        check_val("single.hold_cycles", 8'(hold), 8'd5);
        step(8'h00, "single_gap");
        check_val("single.gap_gnt", gnt, 8'h00);
        for (int i = 0; i < 3; i++) step(8'h00, "single_idle");
        check_val("single.no_regrant", gnt, 8'h00);

        // Reset mid-grant clears outputs without a clock edge
        step(8'h80, "pre_rst");
        step(8'h80, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst.gnt", gnt, 8'h00);
        check_val("async_rst.sel", {5'd0, sel}, 8'd0);
        check_val("async_rst.valid", {7'd0, gnt_valid}, 8'd0);
        model_reset();
        req = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(8'h80, "post_rst");
        check_val("post_rst.gnt", gnt, 8'h80);
        check_val("post_rst.sel", {5'd0, sel}, 8'd7);
        for (int i = 0; i < 3; i++) step(8'h00, "post_rst_rel");

        // Round-robin with wrap: each owner drops for one cycle once granted
        r = 8'hFF;
        for (int c = 0; c < 80 && order.size() < 9; c++) begin
            step(r, "rr");
            if (m_owner >= 0) begin
                if (gnt_valid === 1'b1) order.push_back(int'(sel));
                r = 8'hFF & ~8'(1 << m_owner);
            end else begin
                r = 8'hFF;
            end
        end
        check_val("rr.count", 8'(order.size()), 8'd9);
        for (int i = 0; i < order.size() && i < 9; i++)
            check_val($sformatf("rr.order%0d", i), 8'(order[i]), 8'(i % 8));
        step(8'hFE, "rr_rel");
        step(8'h00, "rr_idle");
        step(8'h00, "rr_idle");

        // Pointer rotation: owner 5 releases, search 6,7,0 picks 0
        step(8'h20, "ptr_g5");
        check_val("ptr.gnt5", gnt, 8'h20);
        step(8'h20, "ptr_hold");
        step(8'h00, "ptr_rel");
        step(8'h21, "ptr_gap");
        step(8'h21, "ptr_pick");
        check_val("ptr.gnt0", gnt, 8'h01);
        for (int i = 0; i < 3; i++) step(8'h00, "ptr_idle");

        // Non-owner pulse while owner 3 holds
        step(8'h08, "nonown_g3");
        step(8'h08, "nonown_hold");
        step(8'h0A, "nonown_pulse");
        check_val("nonown.pulse_gnt", gnt, 8'h08);
        step(8'h08, "nonown_after");
        check_val("nonown.after_gnt", gnt, 8'h08);
        for (int i = 0; i < 4; i++) step(8'h00, "nonown_rel");
        check_val("nonown.never_granted", gnt, 8'h00);

        // Constant two-request load: preemption only with the timeout build
        for (int i = 0; i < 12; i++) step(8'h03, "timeout");
`ifndef MUX_ARB_TIMEOUT_EN
        check_val("timeout.held", gnt, 8'h01);
        check_val("timeout.no_preempt", {7'd0, preempt}, 8'd0);
`endif
        for (int i = 0; i < 3; i++) step(8'h00, "timeout_rel");

        // Randomized: each request bit toggles with low probability
        r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            logic [7:0] flip;
            flip = 8'h00;
            for (int b = 0; b < 8; b++) if ($urandom_range(5) == 0) flip[b] = 1'b1;
            r = r ^ flip;
            step(r, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
